// File: rtl/reg_arb_pkg.sv
// Shared types for the register-port arbiter.
// Contents:
//   WORD_W / ADDR_W  default register width and address width
//   word_t           one register value
//   reg_addr_t       register address
//   arb_state_t      arbiter FSM state encoding
//   req_t            one requester's request bundle {valid, we, addr, wdata}
package reg_arb_pkg;

  localparam int WORD_W = 8;
  localparam int ADDR_W = 2;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    PRI_CORE = 2'd0,
    PRI_DBG  = 2'd1,
    LOCKED   = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic      valid;
    logic      we;
    reg_addr_t addr;
    word_t     wdata;
  } req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant with a debug lock.
//
//   state    | meaning
//   ---------+---------------------------------------------------
//   PRI_CORE | core wins a tie; dbg granted only if core idle
//   PRI_DBG  | dbg wins a tie; core granted only if dbg idle
//   LOCKED   | debug has exclusive access; core never granted
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   core_valid_i  core request present
//   dbg_valid_i   debug request present
//   lock_i        debug requests exclusive access (sampled at the edge)
//   core_gnt_o    core granted this cycle (combinational)
//   dbg_gnt_o     dbg granted this cycle (combinational)
//   locked_o      registered: FSM is in LOCKED
module rr_arb2
  import reg_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic core_valid_i,
  input  logic dbg_valid_i,
  input  logic lock_i,
  output logic core_gnt_o,
  output logic dbg_gnt_o,
  output logic locked_o
);

  arb_state_t state_q, state_d;
  logic       locked_q;

  always_comb begin
    core_gnt_o = 1'b0;
    dbg_gnt_o  = 1'b0;
    state_d    = state_q;

    case (state_q)
      PRI_CORE: begin
        core_gnt_o = core_valid_i;
        dbg_gnt_o  = dbg_valid_i & ~core_valid_i;
      end
      PRI_DBG: begin
        dbg_gnt_o  = dbg_valid_i;
        core_gnt_o = core_valid_i & ~dbg_valid_i;
      end
      LOCKED: begin
        dbg_gnt_o = dbg_valid_i;
      end
      default: ;
    endcase

    // Lock wins over everything; leaving LOCKED (or an illegal code)
    // always restarts with core priority.
    if (lock_i) begin
      state_d = LOCKED;
    end else if (state_q != PRI_CORE && state_q != PRI_DBG) begin
      state_d = PRI_CORE;
    end else if (core_gnt_o) begin
      state_d = PRI_DBG;
    end else if (dbg_gnt_o) begin
      state_d = PRI_CORE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= PRI_CORE;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      locked_q <= (state_d == LOCKED);
    end
  end

  assign locked_o = locked_q;

endmodule

// File: rtl/reg_port_arbiter.sv
// Shares the register file write port and read port 1 between the core
// pipeline and the debug monitor. One operation is granted per cycle;
// read data comes back one cycle after the grant, matching the register
// file's registered read.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   core_req_* / dbg_req_*   request: valid, we, addr, wdata; ready out
//   core_rsp_* / dbg_rsp_*   read response: valid, rdata (0 when not valid)
//   dbg_lock / dbg_locked    exclusive debug access request / status
//   rf_rd_addr, rf_rd_data   register file read port 1
//   rf_wr_addr, rf_wr_data,
//   rf_wr_en                 register file write port
module reg_port_arbiter
  import reg_arb_pkg::*;
#(
  parameter int WORD      = 8,
  parameter int ADDR_SIZE = 2
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 core_req_valid,
  input  logic                 core_req_we,
  input  logic [ADDR_SIZE-1:0] core_req_addr,
  input  logic [WORD-1:0]      core_req_wdata,
  output logic                 core_req_ready,
  output logic                 core_rsp_valid,
  output logic [WORD-1:0]      core_rsp_rdata,

  input  logic                 dbg_req_valid,
  input  logic                 dbg_req_we,
  input  logic [ADDR_SIZE-1:0] dbg_req_addr,
  input  logic [WORD-1:0]      dbg_req_wdata,
  output logic                 dbg_req_ready,
  output logic                 dbg_rsp_valid,
  output logic [WORD-1:0]      dbg_rsp_rdata,

  input  logic                 dbg_lock,
  output logic                 dbg_locked,

  output logic [ADDR_SIZE-1:0] rf_rd_addr,
  input  logic [WORD-1:0]      rf_rd_data,
  output logic [ADDR_SIZE-1:0] rf_wr_addr,
  output logic [WORD-1:0]      rf_wr_data,
  output logic                 rf_wr_en
);

  logic core_gnt, dbg_gnt;

  rr_arb2 u_arb (
    .clk          (clk),
    .rst          (rst),
    .core_valid_i (core_req_valid),
    .dbg_valid_i  (dbg_req_valid),
    .lock_i       (dbg_lock),
    .core_gnt_o   (core_gnt),
    .dbg_gnt_o    (dbg_gnt),
    .locked_o     (dbg_locked)
  );

  assign core_req_ready = core_gnt;
  assign dbg_req_ready  = dbg_gnt;

  // Grants are one-hot, so a simple select on dbg_gnt picks the winner.
  logic                 any_gnt;
  logic                 sel_we;
  logic [ADDR_SIZE-1:0] sel_addr;
  logic [WORD-1:0]      sel_wdata;
  logic                 rd_gnt;

  assign any_gnt   = core_gnt | dbg_gnt;
  assign sel_we    = dbg_gnt ? dbg_req_we    : core_req_we;
  assign sel_addr  = dbg_gnt ? dbg_req_addr  : core_req_addr;
  assign sel_wdata = dbg_gnt ? dbg_req_wdata : core_req_wdata;
  assign rd_gnt    = any_gnt & ~sel_we;

  // The grant is still combinational during reset, so the write strobe
  // is explicitly held off while rst is high.
  assign rf_wr_en   = any_gnt & sel_we & ~rst;
  assign rf_wr_addr = sel_addr;
  assign rf_wr_data = sel_wdata;

  // Holding the last read address keeps rf_rd_data stable between reads.
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  assign rd_addr_d  = rd_gnt ? sel_addr : rd_addr_q;
  assign rf_rd_addr = rd_addr_d;

  logic core_pend_q, core_pend_d;
  logic dbg_pend_q,  dbg_pend_d;
  assign core_pend_d = core_gnt & ~core_req_we;
  assign dbg_pend_d  = dbg_gnt  & ~dbg_req_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr_q   <= '0;
      core_pend_q <= 1'b0;
      dbg_pend_q  <= 1'b0;
    end else begin
      rd_addr_q   <= rd_addr_d;
      core_pend_q <= core_pend_d;
      dbg_pend_q  <= dbg_pend_d;
    end
  end

  assign core_rsp_valid = core_pend_q;
  assign dbg_rsp_valid  = dbg_pend_q;
  assign core_rsp_rdata = core_pend_q ? rf_rd_data : '0;
  assign dbg_rsp_rdata  = dbg_pend_q  ? rf_rd_data : '0;

endmodule

// File: tb/tb_reg_port_arbiter.sv
module tb_reg_port_arbiter;
  import reg_arb_pkg::*;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      core_req_valid = 1'b0, core_req_we = 1'b0;
  reg_addr_t core_req_addr = '0;
  word_t     core_req_wdata = '0;
  logic      core_req_ready, core_rsp_valid;
  word_t     core_rsp_rdata;
  logic      dbg_req_valid = 1'b0, dbg_req_we = 1'b0;
  reg_addr_t dbg_req_addr = '0;
  word_t     dbg_req_wdata = '0;
  logic      dbg_req_ready, dbg_rsp_valid;
  word_t     dbg_rsp_rdata;
  logic      dbg_lock = 1'b0;
  logic      dbg_locked;
  reg_addr_t rf_rd_addr, rf_wr_addr;
  word_t     rf_rd_data = '0;
  word_t     rf_wr_data;
  logic      rf_wr_en;

  reg_port_arbiter #(.WORD(8), .ADDR_SIZE(2)) dut (
    .clk(clk), .rst(rst),
    .core_req_valid(core_req_valid), .core_req_we(core_req_we),
    .core_req_addr(core_req_addr), .core_req_wdata(core_req_wdata),
    .core_req_ready(core_req_ready), .core_rsp_valid(core_rsp_valid),
    .core_rsp_rdata(core_rsp_rdata),
    .dbg_req_valid(dbg_req_valid), .dbg_req_we(dbg_req_we),
    .dbg_req_addr(dbg_req_addr), .dbg_req_wdata(dbg_req_wdata),
    .dbg_req_ready(dbg_req_ready), .dbg_rsp_valid(dbg_rsp_valid),
    .dbg_rsp_rdata(dbg_rsp_rdata),
    .dbg_lock(dbg_lock), .dbg_locked(dbg_locked),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data), .rf_wr_en(rf_wr_en)
  );

  always #5 clk = ~clk;

  // Register file with registered read, as the arbiter expects.
  word_t rf_mem [4] = '{default: '0};
  int    cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rf_wr_en) rf_mem[rf_wr_addr] <= rf_wr_data;
    rf_rd_data <= rf_mem[rf_rd_addr];
  end

  // Reference model: architectural register contents, who has priority,
  // whether debug holds the lock, and the last address read.
  typedef struct {int due; word_t data;} exp_t;
  exp_t      core_q[$];
  exp_t      dbg_q[$];
  word_t     mem_m [4] = '{default: '0};
  logic      locked_m  = 1'b0;
  logic      favor_dbg = 1'b0;
  reg_addr_t rd_addr_m = '0;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic req_t mkreq(input logic v, input logic we, input reg_addr_t a, input word_t d);
    req_t r;
    r.valid = v;
    r.we    = we;
    r.addr  = a;
    r.wdata = d;
    return r;
  endfunction

  // Monitor: pops a response expectation when its due cycle arrives.
  exp_t ce, de;
  always @(negedge clk) begin
    if (!rst) begin
      if (core_q.size() > 0 && core_q[0].due == cyc) begin
        ce = core_q.pop_front();
        chk("core_rsp_valid", core_rsp_valid, 1);
        chk("core_rsp_rdata", core_rsp_rdata, ce.data);
      end else begin
        chk("core_rsp_quiet", core_rsp_valid, 0);
        chk("core_rsp_rdata_zero", core_rsp_rdata, 0);
      end
      if (dbg_q.size() > 0 && dbg_q[0].due == cyc) begin
        de = dbg_q.pop_front();
        chk("dbg_rsp_valid", dbg_rsp_valid, 1);
        chk("dbg_rsp_rdata", dbg_rsp_rdata, de.data);
      end else begin
        chk("dbg_rsp_quiet", dbg_rsp_valid, 0);
        chk("dbg_rsp_rdata_zero", dbg_rsp_rdata, 0);
      end
    end
  end

  task automatic drive_cycle(input req_t c, input req_t d, input logic lk,
                             output logic cg, output logic dg);
    logic      ecg, edg, any, we;
    reg_addr_t ra;
    word_t     wd;
    exp_t      e;
    @(negedge clk);
    core_req_valid = c.valid; core_req_we = c.we;
    core_req_addr  = c.addr;  core_req_wdata = c.wdata;
    dbg_req_valid  = d.valid; dbg_req_we = d.we;
    dbg_req_addr   = d.addr;  dbg_req_wdata = d.wdata;
    dbg_lock       = lk;
    #1;
    if (locked_m) begin
      ecg = 1'b0;            edg = d.valid;
    end else if (favor_dbg) begin
      edg = d.valid;         ecg = c.valid && !d.valid;
    end else begin
      ecg = c.valid;         edg = d.valid && !c.valid;
    end
    chk("core_req_ready", core_req_ready, ecg);
    chk("dbg_req_ready", dbg_req_ready, edg);
    chk("dbg_locked", dbg_locked, locked_m);
    any = ecg | edg;
    we  = edg ? d.we    : c.we;
    ra  = edg ? d.addr  : c.addr;
    wd  = edg ? d.wdata : c.wdata;
    chk("rf_wr_en", rf_wr_en, any && we);
    if (any && we) begin
      chk("rf_wr_addr", rf_wr_addr, ra);
      chk("rf_wr_data", rf_wr_data, wd);
      mem_m[ra] = wd;
    end
    if (any && !we) begin
      rd_addr_m = ra;
      e.due  = cyc + 1;
      e.data = mem_m[ra];
      if (edg) dbg_q.push_back(e); else core_q.push_back(e);
    end
    chk("rf_rd_addr", rf_rd_addr, rd_addr_m);
    if (lk) locked_m = 1'b1;
    else if (locked_m) begin
      locked_m  = 1'b0;
      favor_dbg = 1'b0;
    end else if (any) favor_dbg = ecg;
    cg = ecg;
    dg = edg;
  endtask

  task automatic model_reset();
    core_q.delete();
    dbg_q.delete();
    locked_m  = 1'b0;
    favor_dbg = 1'b0;
    rd_addr_m = '0;
  endtask

  task automatic idle_inputs();
    core_req_valid = 1'b0; core_req_we = 1'b0; core_req_addr = '0; core_req_wdata = '0;
    dbg_req_valid  = 1'b0; dbg_req_we  = 1'b0; dbg_req_addr  = '0; dbg_req_wdata  = '0;
    dbg_lock = 1'b0;
  endtask

  initial begin
    req_t idle, cc, dd;
    logic cg, dg, lk;
    idle = '0;

    // Reset state, including write gating while rst is high.
    #2;
    chk("rst_dbg_locked", dbg_locked, 0);
    chk("rst_core_rsp_valid", core_rsp_valid, 0);
    chk("rst_dbg_rsp_valid", dbg_rsp_valid, 0);
    chk("rst_core_rsp_rdata", core_rsp_rdata, 0);
    chk("rst_dbg_rsp_rdata", dbg_rsp_rdata, 0);
    chk("rst_rf_rd_addr", rf_rd_addr, 0);
    chk("rst_core_ready_idle", core_req_ready, 0);
    chk("rst_dbg_ready_idle", dbg_req_ready, 0);
    core_req_valid = 1'b1; core_req_we = 1'b1; core_req_addr = 2'd1; core_req_wdata = 8'h99;
    #1;
    chk("rst_rf_wr_en_gated", rf_wr_en, 0);
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;

    // Both requesters held valid from reset: grants alternate.
    repeat (6) drive_cycle(mkreq(1, 0, 2'd0, 8'h00), mkreq(1, 0, 2'd1, 8'h00), 1'b0, cg, dg);

    // Core write then read-back of the same address.
    drive_cycle(mkreq(1, 1, 2'd2, 8'hA5), idle, 1'b0, cg, dg);
    drive_cycle(mkreq(1, 0, 2'd2, 8'h00), idle, 1'b0, cg, dg);
    repeat (2) drive_cycle(idle, idle, 1'b0, cg, dg);

    // Debug lock with the core request held, debug write, then unlock.
    drive_cycle(mkreq(1, 0, 2'd0, 8'h00), idle, 1'b1, cg, dg);
    repeat (2) drive_cycle(mkreq(1, 0, 2'd0, 8'h00), mkreq(1, 1, 2'd3, 8'h3C), 1'b1, cg, dg);
    drive_cycle(mkreq(1, 0, 2'd0, 8'h00), idle, 1'b1, cg, dg);
    drive_cycle(mkreq(1, 0, 2'd0, 8'h00), idle, 1'b0, cg, dg);
    drive_cycle(mkreq(1, 0, 2'd0, 8'h00), mkreq(1, 0, 2'd3, 8'h00), 1'b0, cg, dg);
    drive_cycle(idle, mkreq(1, 0, 2'd3, 8'h00), 1'b0, cg, dg);
    repeat (2) drive_cycle(idle, idle, 1'b0, cg, dg);

    // Debug write followed immediately by a core read of the same address.
    drive_cycle(idle, mkreq(1, 1, 2'd1, 8'hFF), 1'b0, cg, dg);
    drive_cycle(mkreq(1, 0, 2'd1, 8'h00), idle, 1'b0, cg, dg);
    repeat (2) drive_cycle(idle, idle, 1'b0, cg, dg);

    // Reset while locked clears the lock asynchronously.
    repeat (2) drive_cycle(idle, idle, 1'b1, cg, dg);
    @(negedge clk);
    idle_inputs();
    #2 rst = 1'b1;
    #1 chk("rst_async_unlock", dbg_locked, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Reset lands on a granted core read: no response, no writes.
    @(negedge clk);
    core_req_valid = 1'b1; core_req_we = 1'b0; core_req_addr = 2'd2;
    dbg_req_valid  = 1'b1; dbg_req_we  = 1'b0; dbg_req_addr  = 2'd1;
    #1 chk("pre_rst_core_granted", core_req_ready, 1);
    #1 rst = 1'b1;
    core_req_we = 1'b1; core_req_addr = 2'd3; core_req_wdata = 8'h77;
    #1 chk("mid_rst_wr_en", rf_wr_en, 0);
    @(posedge clk);
    #1;
    chk("in_rst_wr_en", rf_wr_en, 0);
    chk("in_rst_core_rsp", core_rsp_valid, 0);
    chk("in_rst_dbg_rsp", dbg_rsp_valid, 0);
    idle_inputs();
    #1;
    chk("in_rst_rd_addr", rf_rd_addr, 0);
    chk("in_rst_locked", dbg_locked, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive_cycle(mkreq(1, 0, 2'd0, 8'h00), mkreq(1, 0, 2'd1, 8'h00), 1'b0, cg, dg);
    chk("post_rst_first_grant_core", core_req_ready, 1);
    drive_cycle(idle, mkreq(1, 0, 2'd1, 8'h00), 1'b0, cg, dg);
    drive_cycle(idle, mkreq(1, 0, 2'd3, 8'h00), 1'b0, cg, dg);

    // Idle stretch: nothing granted, read address held.
    repeat (5) drive_cycle(idle, idle, 1'b0, cg, dg);

    // Randomized traffic; requests are held until the model grants them.
    cc = '0; dd = '0; lk = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!cc.valid && $urandom_range(0, 3) != 0)
        cc = mkreq(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      if (!dd.valid && $urandom_range(0, 3) != 0)
        dd = mkreq(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      if (lk) begin
        if ($urandom_range(0, 9) == 0) lk = 1'b0;
      end else if ($urandom_range(0, 59) == 0) lk = 1'b1;
      drive_cycle(cc, dd, lk, cg, dg);
      if (cg) cc.valid = 1'b0;
      if (dg) dd.valid = 1'b0;
    end

    repeat (4) drive_cycle(idle, idle, 1'b0, cg, dg);
    chk("core_q_drained", core_q.size(), 0);
    chk("dbg_q_drained", dbg_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_port_arbiter.md
Name: reg_port_arbiter

Overview:
- Shares the single write port and read port 1 of the register file between two requesters: the core pipeline (requester 0) and the debug/UART monitor (requester 1).
- One operation is granted per cycle, using round-robin arbitration with a debug lock that gives debug exclusive access.
- Read responses are returned one cycle after grant, matching the register file's registered read.
- Sits between the requesters and the register file. Read port 2 is not routed through this block.

Parameters:
- WORD, 8, data width of a register.
- ADDR_SIZE, 2, register address width; the register file holds 2**ADDR_SIZE entries.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- core_req_valid  in  1  core request present.
- core_req_we  in  1  1 = write, 0 = read.
- core_req_addr  in  ADDR_SIZE  register address.
- core_req_wdata  in  WORD  write data.
- core_req_ready  out  1  core request accepted this cycle.
- core_rsp_valid  out  1  core read data valid.
- core_rsp_rdata  out  WORD  core read data.
- dbg_req_valid, dbg_req_we, dbg_req_addr, dbg_req_wdata, dbg_req_ready, dbg_rsp_valid, dbg_rsp_rdata: same as the core ports, for the debug requester.
- dbg_lock  in  1  debug requests exclusive access.
- dbg_locked  out  1  exclusive access is in effect.
- rf_rd_addr  out  ADDR_SIZE  to register file rd_addr1.
- rf_rd_data  in  WORD  from register file rd_data1.
- rf_wr_addr  out  ADDR_SIZE  to register file wr_addr.
- rf_wr_data  out  WORD  to register file wr_data.
- rf_wr_en  out  1  to register file wr_en.

Behaviour:
- Handshake
  - A request transfers in any cycle where valid && ready are both high.
  - Requesters hold valid, we, addr and wdata stable until ready.
  - ready is combinational from the valid inputs and state.
  - ready never depends on the requester's own ready, so there is no combinational loop.
- Grant
  - At most one grant per cycle.
  - ready is asserted only for the granted requester.
  - ready is 0 when valid is 0.
- FSM states: PRI_CORE, PRI_DBG, LOCKED. Reset state is PRI_CORE.
  - PRI_CORE: if core valid, grant core; otherwise, if dbg valid, grant dbg.
  - PRI_DBG: mirror image of PRI_CORE.
  - After any grant, go to the state that prioritises the other requester. With no grant, stay in the current state.
  - Any state goes to LOCKED when dbg_lock=1 at a clock edge.
  - In LOCKED, only dbg can be granted and core_req_ready=0.
  - LOCKED goes to PRI_CORE when dbg_lock=0 at a clock edge.
  - dbg_locked = (state == LOCKED), registered.
  - Unlocked starvation bound: a requester with valid held waits at most 1 cycle.
- Datapath (combinational from the grant)
  - Granted write: rf_wr_en=1, rf_wr_addr=addr, rf_wr_data=wdata.
  - Granted read: rf_rd_addr=addr.
  - With no read granted, rf_rd_addr holds its last driven value via a register, so the read data stays stable.
  - rf_wr_en is gated with !rst.
- Response
  - A read granted in cycle N produces <req>_rsp_valid=1 in cycle N+1 for that requester only, with rsp_rdata=rf_rd_data.
  - Writes produce no response.
  - Responses have no backpressure; the requester must accept them.
- Ordering
  - A write in cycle N followed by a read of the same address in N+1 returns the new value.
  - A read and a write to the same address from different requesters cannot share a cycle (single grant).
- Reset
  - Asynchronous. State goes to PRI_CORE and dbg_locked=0.
  - Both rsp_valid=0, both rsp_rdata=0, rf_rd_addr register=0.
  - rf_wr_en=0 for the whole time rst is high.
  - A read in flight when reset is asserted gets no response.
- rsp_rdata is 0 whenever rsp_valid=0. This is a mux on the valid flag.

Decomposition:
- Package reg_arb_pkg holds:
  - the word and regAddr typedefs, parameterised by WORD and ADDR_SIZE defaults;
  - the arb_state_t enum {PRI_CORE, PRI_DBG, LOCKED};
  - a packed req_t struct {valid, we, addr, wdata}.
- One natural sub-module, rr_arb2: a two-input round-robin grant with a lock input, containing the FSM only.
- The top level holds the datapath muxes and the response pipeline register.

Test Plan:
- Core writes addr 2 = 0xA5; next cycle core reads addr 2 -> core_rsp_valid=1 one cycle after grant with rdata 0xA5; dbg_rsp_valid stays 0.
- Both valid continuously from reset: core reads addr 0, dbg reads addr 1 -> grants alternate core, dbg, core, dbg; each rsp arrives exactly 1 cycle after its grant.
- Assert dbg_lock while core valid is held -> from the next edge dbg_locked=1 and core_req_ready=0. Dbg writes addr 3 = 0x3C. Drop dbg_lock -> core is granted on the first cycle after unlock.
- Dbg writes addr 1 = 0xFF in cycle N, core reads addr 1 in N+1 -> core_rsp_rdata=0xFF in N+2.
- Core read granted, then rst pulsed before the next edge -> no rsp_valid, rf_wr_en=0 throughout reset, FSM returns to PRI_CORE and the first grant after reset goes to core when both are valid.
- Idle (no valid) for 5 cycles -> rf_wr_en=0, both ready=0, both rsp_valid=0, rf_rd_addr unchanged.
